// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the multi-mode shift register datapath.
// Runs one opcode for N cycles, then reports Q with a done pulse.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             R,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_abort,
  output logic [2:0]       S,
  output logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] shifts_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       s_raw;
  logic [WIDTH-1:0] l_raw;

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    s_raw     = 3'b000;
    l_raw     = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = '0;
          if (cmd_op == 3'b111) begin
            rem_d   = CNT_W'(1);
            state_d = RUN;
          end else if (cmd_op == 3'b000 || cmd_amt == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = cmd_amt;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy  = 1'b1;
        l_raw = data_q;
        // abort burns this cycle as a hold and is not counted
        if (cmd_abort) begin
          state_d = DONE;
        end else begin
          s_raw = op_q;
          rem_d = rem_q - CNT_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign S           = R ? 3'b000 : s_raw;
  assign L           = R ? '0 : l_raw;
  assign result      = done ? Q : '0;
  assign shifts_done = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 4-bit datapath.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [2:0] cmd_amt = 3'b000;
  logic [3:0] cmd_data = 4'b0000;
  logic       cmd_abort = 1'b0;
  logic [2:0] S;
  logic [3:0] L;
  logic [3:0] q_m = 4'b0000;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [2:0] shifts_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .R(R),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt),
    .cmd_data(cmd_data), .cmd_abort(cmd_abort),
    .S(S), .L(L), .Q(q_m),
    .busy(busy), .done(done),
    .result(result), .shifts_done(shifts_done)
  );

  always_ff @(posedge clk) begin
    case (S)
      3'b001:  q_m <= {q_m[2:0], q_m[3]};
      3'b010:  q_m <= {q_m[0], q_m[3:1]};
      3'b011:  q_m <= {1'b0, q_m[3:1]};
      3'b100:  q_m <= {q_m[2:0], 1'b0};
      3'b101:  q_m <= {q_m[2:0], 1'b0};
      3'b110:  q_m <= {q_m[3], q_m[3:1]};
      3'b111:  q_m <= L;
      default: q_m <= q_m;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // entered and left 2 time units after an edge, with the DUT in IDLE
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] amt,
                        input logic [3:0] data, input int abort_at,
                        input int n_run, input logic [3:0] exp_res,
                        input logic [2:0] exp_sd);
    chk("ready_idle", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~data;
    for (int i = 1; i <= n_run; i++) begin
      cmd_abort = (i == abort_at);
      #1;
      chk("busy_run", 8'(busy), 8'd1);
      chk("ready_run", 8'(cmd_ready), 8'd0);
      chk("s_run", 8'(S), (i == abort_at) ? 8'd0 : 8'(op));
      chk("l_run", 8'(L), 8'(data));
      step();
    end
    cmd_abort = 1'b0;
    #1;
    chk("done_hi", 8'(done), 8'd1);
    chk("s_done", 8'(S), 8'd0);
    chk("ready_done", 8'(cmd_ready), 8'd0);
    chk("result", 8'(result), 8'(exp_res));
    chk("shifts", 8'(shifts_done), 8'(exp_sd));
    step();
    #1;
    chk("done_lo", 8'(done), 8'd0);
    chk("busy_lo", 8'(busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    R = 1'b1;
    step();
    step();
    #1;
    chk("rst_s", 8'(S), 8'd0);
    chk("rst_l", 8'(L), 8'd0);
    R = 1'b0;
    step();
    #1;
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_sd", 8'(shifts_done), 8'd0);

    do_cmd(3'b111, 3'd0, 4'b1011, 0, 1, 4'b1011, 3'd1);
    do_cmd(3'b001, 3'd3, 4'b0000, 0, 3, 4'b1101, 3'd3);
    do_cmd(3'b111, 3'd5, 4'b1000, 0, 1, 4'b1000, 3'd1);
    do_cmd(3'b110, 3'd2, 4'b0000, 0, 2, 4'b1110, 3'd2);
    do_cmd(3'b000, 3'd5, 4'b0000, 0, 0, 4'b1110, 3'd0);
    do_cmd(3'b001, 3'd0, 4'b0000, 0, 0, 4'b1110, 3'd0);
    do_cmd(3'b111, 3'd0, 4'b0001, 0, 1, 4'b0001, 3'd1);
    do_cmd(3'b100, 3'd7, 4'b0000, 3, 3, 4'b0100, 3'd2);

    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_amt   = 3'd6;
    step();
    cmd_valid = 1'b0;
    #1;
    chk("mr_s1", 8'(S), 8'd2);
    step();
    R = 1'b1;
    #1;
    chk("mr_s_rst", 8'(S), 8'd0);
    chk("mr_l_rst", 8'(L), 8'd0);
    step();
    R = 1'b0;
    #1;
    chk("mr_ready", 8'(cmd_ready), 8'd1);
    chk("mr_busy", 8'(busy), 8'd0);
    chk("mr_done", 8'(done), 8'd0);
    chk("mr_sd", 8'(shifts_done), 8'd0);
    chk("mr_q", 8'(q_m), 8'b0010);

    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_amt   = 3'd1;
    step();
    cmd_op  = 3'b011;
    cmd_amt = 3'd2;
    #1;
    chk("b2b_ready1", 8'(cmd_ready), 8'd0);
    chk("b2b_s1", 8'(S), 8'd1);
    step();
    #1;
    chk("b2b_done1", 8'(done), 8'd1);
    chk("b2b_ready_d", 8'(cmd_ready), 8'd0);
    chk("b2b_res1", 8'(result), 8'b0100);
    chk("b2b_sd1", 8'(shifts_done), 8'd1);
    step();
    #1;
    chk("b2b_idle_rdy", 8'(cmd_ready), 8'd1);
    chk("b2b_idle_s", 8'(S), 8'd0);
    chk("b2b_idle_dn", 8'(done), 8'd0);
    step();
    cmd_valid = 1'b0;
    #1;
    chk("b2b_s2a", 8'(S), 8'd3);
    chk("b2b_ready2", 8'(cmd_ready), 8'd0);
    step();
    #1;
    chk("b2b_s2b", 8'(S), 8'd3);
    step();
    #1;
    chk("b2b_done2", 8'(done), 8'd1);
    chk("b2b_res2", 8'(result), 8'b0001);
    chk("b2b_sd2", 8'(shifts_done), 8'd2);
    step();
    #1;
    chk("b2b_end_rdy", 8'(cmd_ready), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer for the 4-bit multi-mode shift register datapath (ops: hold, circular L/R, logical L/R, arithmetic L/R, load).
- Accepts one command at a time over a valid/ready handshake: opcode, shift amount and load value.
- Drives the datapath's S/L inputs for exactly the required number of clock cycles, then returns the datapath's Q as the result with a one-cycle done pulse.
- Sits between a host/test controller and the shift register; shares the same clk.

Parameters:
- WIDTH, 4, datapath width (L, Q, cmd_data, result).
- CNT_W, 3, shift-amount width; max amount 2^CNT_W-1 (= 7).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  datapath opcode: 000 hold, 001 circ-left, 010 circ-right, 011 logic-right, 100 logic-left, 101 arith-left, 110 arith-right, 111 load.
- cmd_amt  input  CNT_W  number of shift cycles (ignored for load).
- cmd_data  input  WIDTH  load value (used only for op 111).
- cmd_abort  input  1  terminate the running command early.
- S  output  3  opcode to datapath.
- L  output  WIDTH  load value to datapath.
- Q  input  WIDTH  datapath register output.
- busy  output  1  high in RUN or DONE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  Q snapshot; valid while done=1.
- shifts_done  output  CNT_W  number of RUN cycles actually executed for the last command.

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, op_r, data_r, remaining (CNT_W), count (CNT_W).
- Reset (R=1 at an edge):
  - state=IDLE; op_r, data_r, remaining, count = 0.
  - While R=1, S=000 and L=0 combinationally, regardless of state.
  - Reset mid-RUN drops the command: no done pulse, shifts_done=0.
- IDLE:
  - cmd_ready=1, busy=0, S=000, L=0, done=0.
  - Handshake fires on an edge where cmd_valid=1 and cmd_ready=1. It latches op_r=cmd_op and data_r=cmd_data, and clears count.
  - If cmd_op=111: remaining=1, go to RUN.
  - Else if cmd_op=000 or cmd_amt=0: go directly to DONE. No RUN cycles; shifts_done becomes 0.
  - Else: remaining=cmd_amt, go to RUN.
- RUN:
  - cmd_ready=0, busy=1, S=op_r, L=data_r. The datapath performs one operation per RUN cycle.
  - Each edge: remaining-1, count+1. Leave for DONE on the edge where remaining==1, so there are exactly cmd_amt RUN cycles (1 for load).
  - cmd_abort=1 in a RUN cycle: S forced to 000 that cycle (no shift), count not incremented, next state DONE.
- DONE:
  - S=000 (Q held), done=1, result=Q (combinational pass-through; stable because S=000), shifts_done=count (registered, holds until the next command).
  - cmd_ready=0. Next state is IDLE unconditionally.
- Latency: handshake at edge k; RUN cycles k+1..k+N; done high in cycle k+N+1; next command accepted at earliest edge k+N+2.
- cmd_valid held across busy: not accepted until IDLE. Changes to cmd_* during RUN have no effect (latched copies used).
- cmd_abort in IDLE or DONE: ignored.
- Amount wrap: the remaining counter never underflows; amt=0 is handled in IDLE.

Test Plan:
- Load: R pulse, then cmd op=111, data=1011 → 1 RUN cycle with S=111, L=1011; done 2 cycles after handshake; result=1011, shifts_done=1.
- Circular left: Q=1011, op=001, amt=3 → Q sequence 0111, 1110, 1101; done at handshake+4; result=1101, shifts_done=3.
- Arithmetic right: Q=1000, op=110, amt=2 → Q sequence 1100, 1110; result=1110. Then op=000, amt=5 → DONE next cycle, S never leaves 000, result=1110, shifts_done=0.
- Abort: Q=0001, op=100, amt=7; cmd_abort high in the 3rd RUN cycle → Q=0100; S=000 in the abort cycle; done next cycle; result=0100, shifts_done=2.
- Reset mid-RUN: op=010, amt=6; R=1 in the 2nd RUN cycle → S=000 immediately, next cycle IDLE, no done pulse, cmd_ready=1.
- Back-to-back: cmd_valid held high with two queued commands → cmd_ready low throughout RUN/DONE; second command accepted exactly one cycle after done; no cycle with S≠000 between commands except RUN.
